// File: rtl/muldiv_iter.sv
// Iterative 16-bit multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with results driving the register-file write port directly.
module muldiv_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic [2:0]       dstsel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       writeregsel,
  output logic             write,
  output logic             err
);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;
  localparam logic [1:0] OP_ILL  = 2'b11;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] result_q;
  logic [2:0]       wsel_q;
  logic             err_q;

  logic             accept;
  logic             early_err;
  logic [WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] div_res;

  // Conditional add of the multiplicand; the accumulator wraps modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] mul_step(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] m,
                                                 input logic             b);
    return b ? a + m : a;
  endfunction

  // One restoring-division step on {rem,quo}; returns the updated {rem,quo}.
  // The shifted remainder needs WIDTH+1 bits, but once it is known to be >= the
  // divisor the difference is below the divisor and fits in WIDTH bits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] r,
                                                  input logic [WIDTH-1:0] q,
                                                  input logic [WIDTH-1:0] d);
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    r_sh = {r, q[WIDTH-1]};
    diff = r_sh[WIDTH-1:0] - d;
    if (r_sh >= {1'b0, d})
      return {diff, q[WIDTH-2:0], 1'b1};
    else
      return {r_sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
  endfunction

  always_comb begin
    acc_step = mul_step(acc, mcand, mplier[0]);
    div_res  = div_step(rem, quo, dvs);
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    early_err = (op == OP_ILL) ||
                (((op == OP_DIVU) || (op == OP_REMU)) && (srcB == '0));
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = early_err ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST_CNT)
          state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // Datapath: operand capture on accept, one iteration per RUN cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      op_q     <= OP_MUL;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      result_q <= '0;
      wsel_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        op_q   <= op;
        acc    <= '0;
        mcand  <= srcA;
        mplier <= srcB;
        rem    <= '0;
        quo    <= srcA;
        dvs    <= srcB;
        wsel_q <= dstsel;
        err_q  <= early_err;
        if (op == OP_ILL)
          result_q <= '0;
        else if (early_err)
          result_q <= (op == OP_DIVU) ? '1 : srcA;
      end else if (state == S_RUN) begin
        cnt <= cnt + 1'b1;
        if (op_q == OP_MUL) begin
          acc    <= acc_step;
          mcand  <= {mcand[WIDTH-2:0], 1'b0};
          mplier <= {1'b0, mplier[WIDTH-1:1]};
        end else begin
          rem <= div_res[2*WIDTH-1:WIDTH];
          quo <= div_res[WIDTH-1:0];
        end
        if (cnt == LAST_CNT) begin
          case (op_q)
            OP_MUL:  result_q <= acc_step;
            OP_DIVU: result_q <= div_res[WIDTH-1:0];
            default: result_q <= div_res[2*WIDTH-1:WIDTH];
          endcase
        end
      end
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign write       = done & ~err_q;
  assign err         = err_q;
  assign result      = result_q;
  assign writeregsel = wsel_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed bench for muldiv_iter: vector table of single operations plus
// hand-written reset-abort and start-ignore sequences.
module tb_muldiv_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] srcA, srcB;
  logic [2:0]  dstsel;
  logic        busy, done, write, err;
  logic [15:0] result;
  logic [2:0]  writeregsel;

  int n_vec;
  int n_err;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        e;
    int          cyc;
  } vec_t;

  vec_t tbl[16];

  muldiv_iter #(.WIDTH(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst_n), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .dstsel(dstsel), .busy(busy), .done(done), .result(result),
    .writeregsel(writeregsel), .write(write), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op, wait for done (bounded); cyc counts cycles from the accept edge.
  task automatic do_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] d, output int cyc, output logic [15:0] r,
                       output logic e, output logic w, output logic [2:0] ws,
                       output logic [15:0] r_hold);
    @(negedge clk);
    op = o; srcA = a; srcB = b; dstsel = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; srcA = 16'hDEAD; srcB = 16'h0000; dstsel = ~d; op = 2'b11;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    r = result; e = err; w = write; ws = writeregsel;
    @(posedge clk); #1;
    r_hold = result;
  endtask

  initial begin
    int cyc;
    logic [15:0] r, rh;
    logic e, w;
    logic [2:0] ws;
    logic wrote;

    n_vec = 0;
    n_err = 0;
    tbl[0]  = '{2'b00, 16'h0123, 16'h0045, 16'h4E6F, 1'b0, 17};
    tbl[1]  = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17};
    tbl[2]  = '{2'b00, 16'h0100, 16'h0100, 16'h0000, 1'b0, 17};
    tbl[3]  = '{2'b00, 16'h0007, 16'h0009, 16'h003F, 1'b0, 17};
    tbl[4]  = '{2'b00, 16'h1234, 16'h0000, 16'h0000, 1'b0, 17};
    tbl[5]  = '{2'b01, 16'd1000, 16'd7,    16'd142,  1'b0, 17};
    tbl[6]  = '{2'b10, 16'd1000, 16'd7,    16'd6,    1'b0, 17};
    tbl[7]  = '{2'b01, 16'h8000, 16'h0001, 16'h8000, 1'b0, 17};
    tbl[8]  = '{2'b10, 16'h8000, 16'h0001, 16'h0000, 1'b0, 17};
    tbl[9]  = '{2'b01, 16'd5,    16'd9,    16'd0,    1'b0, 17};
    tbl[10] = '{2'b10, 16'd5,    16'd9,    16'd5,    1'b0, 17};
    tbl[11] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17};
    tbl[12] = '{2'b01, 16'h1234, 16'h0000, 16'hFFFF, 1'b1, 1};
    tbl[13] = '{2'b10, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1};
    tbl[14] = '{2'b11, 16'h5555, 16'h0003, 16'h0000, 1'b1, 1};
    tbl[15] = '{2'b10, 16'd100,  16'd3,    16'd1,    1'b0, 17};

    start = 1'b0; op = 2'b00; srcA = '0; srcB = '0; dstsel = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_result", {16'b0, result}, 32'd0);
    chk("rst_wsel", {29'b0, writeregsel}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      logic [2:0] d;
      d = 3'(i + 3);
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, d, cyc, r, e, w, ws, rh);
      n_vec++;
      chk($sformatf("v%0d_result", i), {16'b0, r}, {16'b0, tbl[i].res});
      chk($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, tbl[i].e});
      chk($sformatf("v%0d_write", i), {31'b0, w}, {31'b0, ~tbl[i].e});
      chk($sformatf("v%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("v%0d_wsel", i), {29'b0, ws}, {29'b0, d});
      chk($sformatf("v%0d_hold", i), {16'b0, rh}, {16'b0, tbl[i].res});
      chk($sformatf("v%0d_idle", i), {30'b0, busy, done}, 32'd0);
    end

    // Start held high through RUN and into the done cycle: only the first op runs.
    n_vec++;
    @(negedge clk);
    op = 2'b00; srcA = 16'd3; srcB = 16'd5; dstsel = 3'd6; start = 1'b1;
    @(posedge clk); #1;
    op = 2'b01; srcA = 16'd100; srcB = 16'd3; dstsel = 3'd2;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_first_cycles", cyc, 17);
    chk("b2b_first_result", {16'b0, result}, 32'd15);
    chk("b2b_first_wsel", {29'b0, writeregsel}, 32'd6);
    @(posedge clk); #1;
    chk("b2b_done_start_ignored", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_second_accepted", {31'b0, busy}, 32'd1);
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("b2b_second_cycles", cyc, 17);
    chk("b2b_second_result", {16'b0, result}, 32'd33);
    chk("b2b_second_wsel", {29'b0, writeregsel}, 32'd2);
    @(posedge clk); #1;

    // Asynchronous reset mid-RUN aborts with no write.
    n_vec++;
    @(negedge clk);
    op = 2'b00; srcA = 16'h0123; srcB = 16'h0045; dstsel = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_write", {31'b0, write}, 32'd0);
    chk("abort_result", {16'b0, result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wrote = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (write || done || busy) wrote = 1'b1;
    end
    chk("abort_no_write", {31'b0, wrote}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
